unified_mem_arbiter: RTL and testbench

- Shares one single-ported unified memory between the instruction-fetch requester (read-only) and the data-memory requester (load/store) of the 5-stage pipeline.
- Accepts one request at a time, sequences the memory handshake, and returns a one-cycle acknowledge with read data to the winning requester.
- Drives per-port stall signals that the pipeline ORs into its existing stall/freeze logic.
- Sits between the IF/MEM pipeline stages and the external memory model.

---
 rtl/unified_mem_arbiter_if.sv | 72 +++++++
 rtl/unified_mem_arbiter.sv | 177 +++++++++++++++++
 tb/tb_unified_mem_arbiter.sv | 327 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/unified_mem_arbiter_if.sv
// -----------------------------------------------------------------------------
// unified_mem_arbiter_if
//
// Bundles every handshake signal around the unified memory arbiter:
//   - instruction-fetch requester  (if_*)  read-only
//   - data-memory requester        (d_*)   load/store
//   - shared single-ported memory  (mem_*)
//
// Modports:
//   master : the arbiter side. Takes both requesters' requests and the memory
//            response, drives acks/read data/stalls and the memory request.
//   slave  : the environment side (pipeline stages plus memory model), the
//            mirror image of master.
//
// Parameters:
//   ADDR_W : address width of both requesters and the memory port
//   DATA_W : data width, a multiple of 8 (byte enables are DATA_W/8 wide)
// -----------------------------------------------------------------------------
interface unified_mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    // Instruction-fetch port
    logic                  if_req;
    logic [ADDR_W-1:0]     if_addr;
    logic                  if_ack;
    logic [DATA_W-1:0]     if_rdata;
    logic                  if_stall;

    // Data port
    logic                  d_req;
    logic                  d_we;
    logic [ADDR_W-1:0]     d_addr;
    logic [DATA_W-1:0]     d_wdata;
    logic [DATA_W/8-1:0]   d_be;
    logic                  d_ack;
    logic [DATA_W-1:0]     d_rdata;
    logic                  d_stall;

    // Shared status
    logic                  err;

    // Memory port
    logic                  mem_req;
    logic                  mem_we;
    logic [ADDR_W-1:0]     mem_addr;
    logic [DATA_W-1:0]     mem_wdata;
    logic [DATA_W/8-1:0]   mem_be;
    logic [DATA_W-1:0]     mem_rdata;
    logic                  mem_ready;

    modport master (
        input  if_req, if_addr,
        input  d_req, d_we, d_addr, d_wdata, d_be,
        input  mem_rdata, mem_ready,
        output if_ack, if_rdata, if_stall,
        output d_ack, d_rdata, d_stall,
        output err,
        output mem_req, mem_we, mem_addr, mem_wdata, mem_be
    );

    modport slave (
        output if_req, if_addr,
        output d_req, d_we, d_addr, d_wdata, d_be,
        output mem_rdata, mem_ready,
        input  if_ack, if_rdata, if_stall,
        input  d_ack, d_rdata, d_stall,
        input  err,
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_be
    );

endinterface

// File: rtl/unified_mem_arbiter.sv
// -----------------------------------------------------------------------------
// unified_mem_arbiter
//
// Shares one single-ported unified memory between the instruction-fetch
// requester (read-only) and the data-memory requester (load/store) of the
// 5-stage pipeline. One request is served at a time: the winner's command is
// latched into the mem_* registers, the memory handshake is sequenced, and a
// one-cycle acknowledge with read data is returned to the winner. Per-port
// stall signals are produced for the pipeline's freeze logic.
//
// Ports:
//   clk    : system clock, rising edge
//   reset  : asynchronous, active-low reset
//   bus    : unified_mem_arbiter_if.master
//              if_req/if_addr            -> if_ack/if_rdata/if_stall
//              d_req/d_we/d_addr/d_wdata/d_be -> d_ack/d_rdata/d_stall
//              err (high with the ack of a timed-out transaction)
//              mem_req/mem_we/mem_addr/mem_wdata/mem_be -> memory
//              mem_rdata/mem_ready       <- memory
//
// Parameters:
//   ADDR_W  : address width (default 32)
//   DATA_W  : data width, multiple of 8 (default 32)
//   TIMEOUT : max cycles waiting for mem_ready before abort, 1..255 (default 255)
//
// Build option:
//   ARB_ROUND_ROBIN_EN : when defined, a 1-bit priority pointer decides
//                        simultaneous requests and flips to the losing port
//                        after each completed grant. When undefined, the data
//                        port always wins a simultaneous request.
//
// Timing: request sampled in IDLE (cycle 0), mem_req high from cycle 1,
// mem_ready in cycle k gives the ack in cycle k+1. RESP is always followed by
// an IDLE cycle, so the other port always gets a chance to win.
// -----------------------------------------------------------------------------
module unified_mem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                    clk,
    input  logic                    reset,
    unified_mem_arbiter_if.master   bus
);

    // Last counter value before the transaction is abandoned.
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t     state;
    logic [7:0] wait_cnt;
    logic       owner_d;    // 1: data port owns the current transaction
    logic       grant_d;    // 1: data port wins the IDLE-cycle decision

    // ------------------------------------------------------------------
    // Winner selection
    // ------------------------------------------------------------------
`ifdef ARB_ROUND_ROBIN_EN
    // prio_d = 1 means the data port wins a tie. It flips to the port that
    // lost after every completed grant, bounding fetch starvation behind
    // back-to-back stores to one transaction.
    logic prio_d;

    always_comb begin
        grant_d = bus.d_req & (prio_d | ~bus.if_req);
    end
`else
    // The data port holds the older instruction; letting it win avoids a
    // deadlock where MEM waits on a fetch that waits on MEM.
    always_comb begin
        grant_d = bus.d_req;
    end
`endif

    // Stalls drop in the same cycle the ack is presented.
    assign bus.if_stall = bus.if_req & ~bus.if_ack;
    assign bus.d_stall  = bus.d_req  & ~bus.d_ack;

    // ------------------------------------------------------------------
    // Transaction sequencer: IDLE -> WAIT -> RESP -> IDLE
    // All outputs are registered here.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            wait_cnt      <= 8'd0;
            owner_d       <= 1'b0;
            bus.mem_req   <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            bus.mem_be    <= '0;
            bus.if_ack    <= 1'b0;
            bus.d_ack     <= 1'b0;
            bus.err       <= 1'b0;
            bus.if_rdata  <= '0;
            bus.d_rdata   <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            prio_d        <= 1'b1;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (bus.if_req || bus.d_req) begin
                        owner_d       <= grant_d;
                        // A fetch never writes: force we/wdata/be to 0.
                        bus.mem_we    <= grant_d & bus.d_we;
                        bus.mem_addr  <= grant_d ? bus.d_addr  : bus.if_addr;
                        bus.mem_wdata <= grant_d ? bus.d_wdata : '0;
                        bus.mem_be    <= grant_d ? bus.d_be    : '0;
                        wait_cnt      <= 8'd0;
                        bus.mem_req   <= 1'b1;
                        state         <= WAIT;
                    end
                end

                WAIT: begin
                    // Command registers are untouched here, so mem_* stay
                    // stable and requester-side changes are ignored.
                    if (bus.mem_ready) begin
                        bus.mem_req <= 1'b0;
                        if (owner_d) begin
                            bus.d_rdata <= bus.mem_rdata;
                            bus.d_ack   <= 1'b1;
                        end else begin
                            bus.if_rdata <= bus.mem_rdata;
                            bus.if_ack   <= 1'b1;
                        end
                        state <= RESP;
                    end else if (wait_cnt == CNT_LAST) begin
                        // Abort: still acknowledge the owner so the pipeline
                        // unfreezes, but flag the error and return zero data.
                        bus.mem_req <= 1'b0;
                        bus.err     <= 1'b1;
                        if (owner_d) begin
                            bus.d_rdata <= '0;
                            bus.d_ack   <= 1'b1;
                        end else begin
                            bus.if_rdata <= '0;
                            bus.if_ack   <= 1'b1;
                        end
                        state <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end

                RESP: begin
                    // The ack/err set on entry are visible for exactly this
                    // cycle; the mandatory IDLE that follows blocks
                    // back-to-back grants.
                    bus.if_ack <= 1'b0;
                    bus.d_ack  <= 1'b0;
                    bus.err    <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
                    prio_d     <= ~owner_d;
`endif
                    state      <= IDLE;
                end

                default: begin
                    bus.mem_req <= 1'b0;
                    bus.if_ack  <= 1'b0;
                    bus.d_ack   <= 1'b0;
                    bus.err     <= 1'b0;
                    state       <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_unified_mem_arbiter
//
// Scoreboard bench for unified_mem_arbiter. Stimulus pushes the expected
// memory command (plus the memory model's latency/data) and the expected
// requester response into queues; a memory responder and an ack monitor pop
// and compare independently. dut0 uses the default TIMEOUT, dut1 uses
// TIMEOUT=4 for the abort scenario.
// -----------------------------------------------------------------------------
module tb_unified_mem_arbiter;

    logic clk;
    logic reset;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        is_d;
        logic [31:0] rdata;
        logic        err;
    } rsp_t;

    typedef struct {
        int          lat;
        logic [31:0] rdata;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } mem_t;

    rsp_t q0[$];
    rsp_t q1[$];
    mem_t mq[$];

    rsp_t r0;
    rsp_t r1;
    mem_t m_cur;
    bit   m_active = 1'b0;
    int   m_cnt    = 0;

    unified_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus0 ();
    unified_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus1 ();

    unified_mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut0 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus0)
    );

    unified_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running, required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %h required %h", name, act, exp);
        end
    endtask

    task automatic push_mem(input int lat, input logic [31:0] rdata, input logic we,
                            input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] be);
        mem_t m;
        m.lat = lat; m.rdata = rdata; m.we = we; m.addr = addr; m.wdata = wdata; m.be = be;
        mq.push_back(m);
    endtask

    task automatic push_rsp(input bit sel1, input logic is_d, input logic [31:0] rdata, input logic err);
        rsp_t r;
        r.is_d = is_d; r.rdata = rdata; r.err = err;
        if (sel1) q1.push_back(r);
        else      q0.push_back(r);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits (bounded) for the ack on dut0 and checks the cycle count.
    task automatic wait_ack0(input bit is_d, input int exp_n, input string name);
        int n = 0;
        bit got = 1'b0;
        while (!got && n < 40) begin
            tick();
            n++;
            got = is_d ? bus0.d_ack : bus0.if_ack;
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL %s: no ack within 40 cycles, required ack after %0d", name, exp_n);
        end else begin
            check(name, 32'(n), 32'(exp_n));
        end
    endtask

    // Memory model for dut0: serves mq entries and checks the latched command
    // on every cycle mem_req is high.
    initial begin
        bus0.mem_ready = 1'b0;
        bus0.mem_rdata = 32'h0;
        forever begin
            tick();
            bus0.mem_ready = 1'b0;
            if (bus0.mem_req) begin
                if (!m_active) begin
                    m_active = 1'b1;
                    m_cnt    = 0;
                    if (mq.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_mem_req: mem_addr %h, required no transaction", bus0.mem_addr);
                        m_cur.lat = 1; m_cur.rdata = 32'h0; m_cur.we = 1'b0;
                        m_cur.addr = 32'h0; m_cur.wdata = 32'h0; m_cur.be = 4'h0;
                    end else begin
                        m_cur = mq.pop_front();
                        check("mem_we",    32'(bus0.mem_we), 32'(m_cur.we));
                        check("mem_wdata", bus0.mem_wdata,   m_cur.wdata);
                        check("mem_be",    32'(bus0.mem_be), 32'(m_cur.be));
                    end
                end
                check("mem_addr", bus0.mem_addr, m_cur.addr);
                m_cnt++;
                if (m_cnt == m_cur.lat) begin
                    bus0.mem_ready = 1'b1;
                    bus0.mem_rdata = m_cur.rdata;
                end
            end else begin
                m_active = 1'b0;
            end
        end
    end

    // Ack monitors
    always @(negedge clk) begin
        if (bus0.if_ack || bus0.d_ack) begin
            if (q0.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_ack0: if_ack %0b d_ack %0b, required no ack", bus0.if_ack, bus0.d_ack);
            end else begin
                r0 = q0.pop_front();
                check("ack_port0",  32'(bus0.d_ack), 32'(r0.is_d));
                check("ack_other0", 32'(r0.is_d ? bus0.if_ack : bus0.d_ack), 32'h0);
                check("rdata0",     r0.is_d ? bus0.d_rdata : bus0.if_rdata, r0.rdata);
                check("err0",       32'(bus0.err), 32'(r0.err));
            end
        end
    end

    always @(negedge clk) begin
        if (bus1.if_ack || bus1.d_ack) begin
            if (q1.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_ack1: if_ack %0b d_ack %0b, required no ack", bus1.if_ack, bus1.d_ack);
            end else begin
                r1 = q1.pop_front();
                check("ack_port1",  32'(bus1.d_ack), 32'(r1.is_d));
                check("ack_other1", 32'(r1.is_d ? bus1.if_ack : bus1.d_ack), 32'h0);
                check("rdata1",     r1.is_d ? bus1.d_rdata : bus1.if_rdata, r1.rdata);
                check("err1",       32'(bus1.err), 32'(r1.err));
            end
        end
    end

    initial begin
        int hi;
        int ack_at;

        reset = 1'b0;
        bus0.if_req = 0; bus0.if_addr = 0; bus0.d_req = 0; bus0.d_we = 0;
        bus0.d_addr = 0; bus0.d_wdata = 0; bus0.d_be = 0;
        bus1.if_req = 0; bus1.if_addr = 0; bus1.d_req = 0; bus1.d_we = 0;
        bus1.d_addr = 0; bus1.d_wdata = 0; bus1.d_be = 0;
        bus1.mem_ready = 0; bus1.mem_rdata = 0;

        // Reset state
        repeat (3) tick();
        check("rst_mem_req",  32'(bus0.mem_req), 32'h0);
        check("rst_if_ack",   32'(bus0.if_ack),  32'h0);
        check("rst_d_ack",    32'(bus0.d_ack),   32'h0);
        check("rst_err",      32'(bus0.err),     32'h0);
        check("rst_mem_addr", bus0.mem_addr,     32'h0);
        check("rst_if_rdata", bus0.if_rdata,     32'h0);
        reset = 1'b1;
        tick();

        // Lone fetch
        push_mem(1, 32'h0051_0093, 1'b0, 32'h0000_0010, 32'h0, 4'h0);
        push_rsp(0, 1'b0, 32'h0051_0093, 1'b0);
        bus0.if_req = 1; bus0.if_addr = 32'h0000_0010;
        #1 check("if_stall_req", 32'(bus0.if_stall), 32'h1);
        wait_ack0(0, 2, "lat_fetch");
        check("if_stall_ack", 32'(bus0.if_stall), 32'h0);
        tick();
        bus0.if_req = 0;

        // Simultaneous store + fetch: store first, then an IDLE gap
        tick();
        push_mem(1, 32'hA5A5_A5A5, 1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 4'hF);
        push_mem(1, 32'h0000_0113, 1'b0, 32'h0000_0020, 32'h0, 4'h0);
        push_rsp(0, 1'b1, 32'hA5A5_A5A5, 1'b0);
        push_rsp(0, 1'b0, 32'h0000_0113, 1'b0);
        bus0.d_req = 1; bus0.d_we = 1; bus0.d_addr = 32'h100;
        bus0.d_wdata = 32'hDEAD_BEEF; bus0.d_be = 4'hF;
        bus0.if_req = 1; bus0.if_addr = 32'h20;
        wait_ack0(1, 2, "lat_store_first");
        check("if_stall_wait", 32'(bus0.if_stall), 32'h1);
        tick();
        bus0.d_req = 0; bus0.d_we = 0; bus0.d_wdata = 0; bus0.d_be = 0;
        check("idle_gap", 32'(bus0.mem_req), 32'h0);
        wait_ack0(0, 2, "lat_fetch_after_store");
        check("d_rdata_hold", bus0.d_rdata, 32'hA5A5_A5A5);
        tick();
        bus0.if_req = 0;

        // Slow memory load; address changes during WAIT must be ignored
        tick();
        push_mem(7, 32'hCAFE_F00D, 1'b0, 32'h0000_0200, 32'h0, 4'h0);
        push_rsp(0, 1'b1, 32'hCAFE_F00D, 1'b0);
        bus0.d_req = 1; bus0.d_addr = 32'h200;
        tick();
        bus0.d_addr = 32'hFFFF_FFF0;
        wait_ack0(1, 7, "lat_slow");
        tick();
        bus0.d_req = 0;

        // Held fetch request: three grants spaced by 3 cycles
        tick();
        for (int i = 0; i < 3; i++) begin
            push_mem(1, 32'h0000_1000 + 32'(i), 1'b0, 32'h0000_0040, 32'h0, 4'h0);
            push_rsp(0, 1'b0, 32'h0000_1000 + 32'(i), 1'b0);
        end
        bus0.if_req = 1; bus0.if_addr = 32'h40;
        wait_ack0(0, 2, "held_1");
        wait_ack0(0, 3, "held_2");
        wait_ack0(0, 3, "held_3");
        tick();
        bus0.if_req = 0;

        // Requester drops req before ack: transaction still completes
        tick();
        push_mem(3, 32'h1234_5678, 1'b0, 32'h0000_0300, 32'h0, 4'h0);
        push_rsp(0, 1'b1, 32'h1234_5678, 1'b0);
        bus0.d_req = 1; bus0.d_addr = 32'h300;
        tick();
        bus0.d_req = 0;
        wait_ack0(1, 3, "lat_dropped");
        repeat (2) tick();

        // Reset mid-WAIT, then a pending fetch is granted fresh
        push_mem(100, 32'h0, 1'b0, 32'h0000_0050, 32'h0, 4'h0);
        bus0.if_req = 1; bus0.if_addr = 32'h50;
        repeat (2) tick();
        #2 reset = 1'b0;
        #1;
        check("rst_wait_mem_req", 32'(bus0.mem_req), 32'h0);
        check("rst_wait_d_rdata", bus0.d_rdata,      32'h0);
        check("rst_wait_if_rdata", bus0.if_rdata,    32'h0);
        tick();
        push_mem(1, 32'h0000_0077, 1'b0, 32'h0000_0050, 32'h0, 4'h0);
        push_rsp(0, 1'b0, 32'h0000_0077, 1'b0);
        reset = 1'b1;
        wait_ack0(0, 2, "lat_after_reset");
        tick();
        bus0.if_req = 0;

        // dut1 (TIMEOUT=4): normal load, timed-out load, normal load
        tick();
        push_rsp(1, 1'b1, 32'h5555_AAAA, 1'b0);
        bus1.d_req = 1; bus1.d_addr = 32'h400;
        tick();
        bus1.mem_ready = 1; bus1.mem_rdata = 32'h5555_AAAA;
        tick();
        bus1.mem_ready = 0; bus1.d_req = 0;
        tick();

        push_rsp(1, 1'b1, 32'h0, 1'b1);
        bus1.d_req = 1; bus1.d_addr = 32'h404; bus1.mem_rdata = 32'hBAD0_BAD0;
        hi = 0;
        ack_at = 0;
        for (int i = 1; i <= 12; i++) begin
            tick();
            if (bus1.mem_req) hi++;
            if (bus1.d_ack) begin
                ack_at = i;
                break;
            end
        end
        check("timeout_wait_cycles", 32'(hi),     32'd4);
        check("timeout_ack_cycle",   32'(ack_at), 32'd5);
        bus1.d_req = 0;
        tick();

        push_rsp(1, 1'b1, 32'h0F0F_0F0F, 1'b0);
        bus1.d_req = 1; bus1.d_addr = 32'h408;
        tick();
        bus1.mem_ready = 1; bus1.mem_rdata = 32'h0F0F_0F0F;
        tick();
        bus1.mem_ready = 0; bus1.d_req = 0;

        repeat (5) tick();
        check("q0_drained", 32'(q0.size()), 32'h0);
        check("q1_drained", 32'(q1.size()), 32'h0);
        check("mq_drained", 32'(mq.size()), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
